// File: rtl/uart_loader_pkg.sv
// Shared command/reply codes and FSM state encodings for the UART boot loader.
// Purely declarative: no logic, no latency, no flow control.
package uart_loader_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_DUMP = 8'h44;
    localparam logic [7:0] CMD_RUN  = 8'h52;

    localparam logic [7:0] RPL_OK   = 8'h4B;
    localparam logic [7:0] RPL_HALT = 8'h48;
    localparam logic [7:0] RPL_ERR  = 8'h3F;

    typedef enum logic [3:0] {
        IDLE, ARGH, ARGL, ARGC, LOAD, DRD, DW1, DW2, DTX, RUN, REPLY, TXGAP
    } state_t;

    typedef enum logic [1:0] {
        G_IDLE, G_WAIT, G_PULSE, G_GAP
    } gate_state_t;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_LOAD) || (b == CMD_DUMP) || (b == CMD_RUN);
    endfunction

endpackage

// File: rtl/uart_loader_tx_gate.sv
// One-byte holding stage in front of the UART transmitter; transmit pulses >=1 cycle after send.
// Holds the byte until is_transmitting drops, then pulses and inserts one dead cycle before ready again.
module uart_tx_gate (
    input  logic       clk,
    input  logic       rst,
    input  logic       send_vld,
    input  logic [7:0] send_dat,
    output logic       send_rdy,
    input  logic       is_transmitting,
    output logic [7:0] tx_byte,
    output logic       transmit
);
    import uart_loader_pkg::*;

    gate_state_t state;

    assign send_rdy = (state == G_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= G_IDLE;
            tx_byte  <= 8'h00;
            transmit <= 1'b0;
        end else begin
            transmit <= 1'b0;
            case (state)
                G_IDLE: begin
                    if (send_vld) begin
                        tx_byte <= send_dat;
                        state   <= G_WAIT;
                    end
                end
                G_WAIT: begin
                    if (!is_transmitting) begin
                        transmit <= 1'b1;
                        state    <= G_PULSE;
                    end
                end
                // the UART raises is_transmitting late; keep one cycle quiet after the pulse
                G_PULSE: state <= G_GAP;
                G_GAP:   state <= G_IDLE;
                default: state <= G_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_loader.sv
// Host monitor: 'L' load / 'D' dump / 'R' run commands over UART to RAM and cpu; writes land 1 cycle after rx.
// Replies wait on the tx gate; rx bytes outside command/arg/load phases are dropped. LOADER_CHECKSUM_EN adds sums.
module uart_loader #(
    parameter int addr_width = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  received,
    input  logic [7:0]            rx_byte,
    output logic [7:0]            tx_byte,
    output logic                  transmit,
    input  logic                  is_transmitting,
    output logic [addr_width-1:0] l_raddr,
    output logic [addr_width-1:0] l_waddr,
    output logic [7:0]            dwrite,
    output logic                  write_en,
    input  logic [7:0]            dread,
    output logic                  cpu_start,
    output logic [addr_width-1:0] startaddr,
    input  logic                  cpu_halted,
    output logic                  cpu_active
);
    import uart_loader_pkg::*;

    localparam int AW = addr_width;

    state_t          state;
    state_t          tx_next;
    logic [7:0]      cmd;
    logic [7:0]      hi;
    logic [7:0]      cnt;
    logic [7:0]      tx_dat;
    logic [AW-1:0]   addr;
    logic [AW-1:0]   arg_addr;
    logic            gate_rdy;
    logic            gate_send;

    assign arg_addr  = AW'({hi, rx_byte});
    assign gate_send = gate_rdy && ((state == REPLY) || (state == DTX));

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sum <= 8'h00;
        end else if (state == ARGC && received) begin
            sum <= 8'h00;
        end else if (state == LOAD && received) begin
            sum <= sum + rx_byte;
        end else if (state == DW2) begin
            sum <= sum + dread;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            tx_next    <= IDLE;
            cmd        <= 8'h00;
            hi         <= 8'h00;
            cnt        <= 8'h00;
            tx_dat     <= 8'h00;
            addr       <= '0;
            l_raddr    <= '0;
            l_waddr    <= '0;
            dwrite     <= 8'h00;
            write_en   <= 1'b0;
            cpu_start  <= 1'b0;
            startaddr  <= '0;
            cpu_active <= 1'b0;
        end else begin
            write_en  <= 1'b0;
            cpu_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (received) begin
                        cmd <= rx_byte;
                        if (is_cmd(rx_byte)) begin
                            state <= ARGH;
                        end else begin
                            tx_dat  <= RPL_ERR;
                            tx_next <= IDLE;
                            state   <= REPLY;
                        end
                    end
                end
                ARGH: begin
                    if (received) begin
                        hi    <= rx_byte;
                        state <= ARGL;
                    end
                end
                ARGL: begin
                    if (received) begin
                        addr <= arg_addr;
                        if (cmd == CMD_RUN) begin
                            startaddr  <= arg_addr;
                            cpu_start  <= 1'b1;
                            cpu_active <= 1'b1;
                            state      <= RUN;
                        end else begin
                            state <= ARGC;
                        end
                    end
                end
                ARGC: begin
                    if (received) begin
                        cnt   <= rx_byte;
                        state <= (cmd == CMD_LOAD) ? LOAD : DRD;
                    end
                end
                // a count of 0 runs 256 bytes: it only matches 1 after wrapping through 255
                LOAD: begin
                    if (received) begin
                        l_waddr  <= addr;
                        dwrite   <= rx_byte;
                        write_en <= 1'b1;
                        addr     <= addr + AW'(1);
                        cnt      <= cnt - 8'd1;
                        if (cnt == 8'd1) begin
`ifdef LOADER_CHECKSUM_EN
                            tx_dat <= sum + rx_byte;
`else
                            tx_dat <= RPL_OK;
`endif
                            tx_next <= IDLE;
                            state   <= REPLY;
                        end
                    end
                end
                DRD: begin
                    l_raddr <= addr;
                    addr    <= addr + AW'(1);
                    state   <= DW1;
                end
                DW1: state <= DW2;
                DW2: begin
                    tx_dat <= dread;
                    cnt    <= cnt - 8'd1;
`ifdef LOADER_CHECKSUM_EN
                    tx_next <= (cnt == 8'd1) ? REPLY : DRD;
`else
                    tx_next <= (cnt == 8'd1) ? IDLE : DRD;
`endif
                    state  <= DTX;
                end
                DTX, REPLY: begin
                    if (gate_rdy) state <= TXGAP;
                end
                TXGAP: begin
                    if (gate_rdy) begin
                        state <= tx_next;
`ifdef LOADER_CHECKSUM_EN
                        if (tx_next == REPLY) begin
                            tx_dat  <= sum;
                            tx_next <= IDLE;
                        end
`endif
                    end
                end
                RUN: begin
                    if (cpu_halted) begin
                        cpu_active <= 1'b0;
                        tx_dat     <= RPL_HALT;
                        tx_next    <= IDLE;
                        state      <= REPLY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    uart_tx_gate u_tx_gate (
        .clk             (clk),
        .rst             (rst),
        .send_vld        (gate_send),
        .send_dat        (tx_dat),
        .send_rdy        (gate_rdy),
        .is_transmitting (is_transmitting),
        .tx_byte         (tx_byte),
        .transmit        (transmit)
    );

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: table of host commands plus run / 256-byte / reset-abort sequences.
module tb_uart_loader;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          received;
    logic [7:0]    rx_byte;
    logic [7:0]    tx_byte;
    logic          transmit;
    logic          is_transmitting = 1'b0;
    logic [AW-1:0] l_raddr;
    logic [AW-1:0] l_waddr;
    logic [7:0]    dwrite;
    logic          write_en;
    logic [7:0]    dread;
    logic          cpu_start;
    logic [AW-1:0] startaddr;
    logic          cpu_halted;
    logic          cpu_active;

    always #5 clk = ~clk;

    uart_loader #(.addr_width(AW)) dut (
        .clk(clk), .rst(rst), .received(received), .rx_byte(rx_byte),
        .tx_byte(tx_byte), .transmit(transmit), .is_transmitting(is_transmitting),
        .l_raddr(l_raddr), .l_waddr(l_waddr), .dwrite(dwrite), .write_en(write_en),
        .dread(dread), .cpu_start(cpu_start), .startaddr(startaddr),
        .cpu_halted(cpu_halted), .cpu_active(cpu_active)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // RAM model: one registered read stage
    logic [7:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (write_en) mem[l_waddr] <= dwrite;
        dread <= mem[l_raddr];
    end

    logic [7:0]  txq [$];
    logic [16:0] wq  [$];
    logic        tx_hold = 1'b0;
    int          busy = 0;
    int          tx_pulses = 0;

    // UART transmitter + scoreboards, sampled on the falling edge
    always @(negedge clk) begin
        logic [7:0]  et;
        logic [16:0] ew;
        if (transmit) begin
            tx_pulses++;
            check("tx_while_busy", {31'd0, is_transmitting}, 32'd0);
            if (txq.size() == 0) begin
                checks++; errors++;
                $display("FAIL tx_unexpected: got %02h expected none", tx_byte);
            end else begin
                et = txq.pop_front();
                check("tx_byte", {24'd0, tx_byte}, {24'd0, et});
            end
            busy = 6;
        end else if (busy > 0) begin
            busy--;
        end
        is_transmitting = tx_hold || (busy > 0);
        if (write_en) begin
            if (wq.size() == 0) begin
                checks++; errors++;
                $display("FAIL wr_unexpected: got %03h=%02h expected none", l_waddr, dwrite);
            end else begin
                ew = wq.pop_front();
                check("wr_addr", {23'd0, l_waddr}, {23'd0, ew[16:8]});
                check("wr_data", {24'd0, dwrite}, {24'd0, ew[7:0]});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit exp_wr);
        @(posedge clk); #1 received = 1'b1; rx_byte = b;
        @(posedge clk); #1 received = 1'b0;
        if (exp_wr) check("write_next_cycle", {31'd0, write_en}, 32'd1);
        @(posedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((txq.size() != 0 || wq.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (txq.size() != 0 || wq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: tx left %0d wr left %0d expected 0 0", txq.size(), wq.size());
        end
        repeat (12) @(posedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tx_byte"},   {24'd0, tx_byte}, 32'd0);
        check({tag, "_transmit"},  {31'd0, transmit}, 32'd0);
        check({tag, "_l_raddr"},   {23'd0, l_raddr}, 32'd0);
        check({tag, "_l_waddr"},   {23'd0, l_waddr}, 32'd0);
        check({tag, "_dwrite"},    {24'd0, dwrite}, 32'd0);
        check({tag, "_write_en"},  {31'd0, write_en}, 32'd0);
        check({tag, "_cpu_start"}, {31'd0, cpu_start}, 32'd0);
        check({tag, "_startaddr"}, {23'd0, startaddr}, 32'd0);
        check({tag, "_cpu_active"},{31'd0, cpu_active}, 32'd0);
    endtask

    typedef struct packed {
        logic [3:0]       nb;
        logic [0:7][7:0]  b;
        logic [2:0]       ntx;
        logic [0:5][7:0]  tx;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]    s;
        logic [AW-1:0] wa;
        int            p0;

        // L/D with address wrap, bad command, upper address bits ignored
        vecs[0] = '{4'd8, {8'h4C, 8'h01, 8'hFE, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD}, 3'd1, {8'h4B, 40'h0}};
        vecs[1] = '{4'd4, {8'h44, 8'h01, 8'hFE, 8'h04, 32'h0}, 3'd4, {8'hAA, 8'hBB, 8'hCC, 8'hDD, 16'h0}};
        vecs[2] = '{4'd1, {8'h5A, 56'h0}, 3'd1, {8'h3F, 40'h0}};
        vecs[3] = '{4'd4, {8'h44, 8'h00, 8'h00, 8'h01, 32'h0}, 3'd1, {8'hCC, 40'h0}};
        vecs[4] = '{4'd6, {8'h4C, 8'h00, 8'h05, 8'h02, 8'h11, 8'h22, 16'h0}, 3'd1, {8'h4B, 40'h0}};
        vecs[5] = '{4'd4, {8'h44, 8'h00, 8'h05, 8'h02, 32'h0}, 3'd2, {8'h11, 8'h22, 32'h0}};
        vecs[6] = '{4'd5, {8'h4C, 8'hFE, 8'h05, 8'h01, 8'h77, 24'h0}, 3'd1, {8'h4B, 40'h0}};
        vecs[7] = '{4'd4, {8'h44, 8'h00, 8'h05, 8'h02, 32'h0}, 3'd2, {8'h77, 8'h22, 32'h0}};

        rst = 1'b0; received = 1'b0; rx_byte = 8'h00; cpu_halted = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_outputs_zero("reset");
        rst = 1'b1;
        repeat (2) @(posedge clk);

        for (int v = 0; v < NV; v++) begin
            s = 8'h00;
            if (vecs[v].b[0] == 8'h4C) begin
                wa = AW'({vecs[v].b[1], vecs[v].b[2]});
                for (int i = 4; i < int'(vecs[v].nb); i++) begin
                    wq.push_back({wa + AW'(i - 4), vecs[v].b[i]});
                    s = s + vecs[v].b[i];
                end
`ifdef LOADER_CHECKSUM_EN
                txq.push_back(s);
`else
                txq.push_back(vecs[v].tx[0]);
`endif
            end else begin
                for (int i = 0; i < int'(vecs[v].ntx); i++) begin
                    txq.push_back(vecs[v].tx[i]);
                    s = s + vecs[v].tx[i];
                end
`ifdef LOADER_CHECKSUM_EN
                if (vecs[v].b[0] == 8'h44) txq.push_back(s);
`endif
            end
            for (int i = 0; i < int'(vecs[v].nb); i++)
                send_byte(vecs[v].b[i], (vecs[v].b[0] == 8'h4C) && (i >= 4));
            wait_drain(2000);
        end

        // run: start pulse, bytes ignored while cpu owns the UART, halt reply
        send_byte(8'h52, 1'b0);
        send_byte(8'h00, 1'b0);
        @(posedge clk); #1 received = 1'b1; rx_byte = 8'h10;
        @(posedge clk); #1 received = 1'b0;
        check("run_cpu_start", {31'd0, cpu_start}, 32'd1);
        check("run_cpu_active", {31'd0, cpu_active}, 32'd1);
        check("run_startaddr", {23'd0, startaddr}, 32'h010);
        @(posedge clk); #1;
        check("run_start_one_cycle", {31'd0, cpu_start}, 32'd0);
        check("run_active_held", {31'd0, cpu_active}, 32'd1);
        send_byte(8'h5A, 1'b0);
        repeat (50) @(posedge clk);
        txq.push_back(8'h48);
        #1 cpu_halted = 1'b1;
        @(posedge clk); #1 cpu_halted = 1'b0;
        check("halt_active_drop", {31'd0, cpu_active}, 32'd0);
        wait_drain(500);

        // stray halt in IDLE must produce nothing
        @(posedge clk); #1 cpu_halted = 1'b1;
        @(posedge clk); #1 cpu_halted = 1'b0;
        repeat (20) @(posedge clk);

        // 256-byte load, reply held off by a busy transmitter
        s = 8'h00;
        for (int i = 0; i < 256; i++) begin
            wq.push_back({AW'(i), 8'(i) ^ 8'h5A});
            s = s + (8'(i) ^ 8'h5A);
        end
`ifdef LOADER_CHECKSUM_EN
        txq.push_back(s);
`else
        txq.push_back(8'h4B);
`endif
        send_byte(8'h4C, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 256; i++) begin
            if (i == 255) tx_hold = 1'b1;
            send_byte(8'(i) ^ 8'h5A, 1'b1);
        end
        p0 = tx_pulses;
        repeat (100) @(posedge clk);
        check("tx_held_off", tx_pulses, p0);
        check("load256_writes_done", wq.size(), 0);
        tx_hold = 1'b0;
        wait_drain(500);

        txq.push_back(8'hA5);
`ifdef LOADER_CHECKSUM_EN
        txq.push_back(8'hA5);
`endif
        send_byte(8'h44, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h01, 1'b0);
        wait_drain(500);

        // reset in the middle of a load
        wq.push_back({AW'(9'h020), 8'h31});
        wq.push_back({AW'(9'h021), 8'h32});
        send_byte(8'h4C, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h31, 1'b1);
        send_byte(8'h32, 1'b1);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check_outputs_zero("abort");
        rst = 1'b1;
        repeat (30) @(posedge clk);
        check("abort_two_writes", wq.size(), 0);

        txq.push_back(8'h31);
        txq.push_back(8'h32);
`ifdef LOADER_CHECKSUM_EN
        txq.push_back(8'h63);
`endif
        send_byte(8'h44, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h02, 1'b0);
        wait_drain(500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
